// File: rtl/wb_single_master_if.sv
// -----------------------------------------------------------------------------
// wb_single_master_if
//
// Bundles the three signal groups of the single-transfer Wishbone master:
//   cmd_* : host command port   (valid/ready, host -> master)
//   rsp_* : host response port  (valid/ready, master -> host)
//   wb_*  : Wishbone pipelined-mode initiator signals
//
// Port summary (direction as seen by the master):
//   cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i   in
//   cmd_ready_o                                              out
//   rsp_ready_i                                              in
//   rsp_valid_o, rsp_dat_o, rsp_status_o                     out
//   wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o out
//   wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i, wb_stall_i       in
//
// Modports:
//   master : the wb_single_master view
//   slave  : the environment view (host + interconnect)
// -----------------------------------------------------------------------------
interface wb_single_master_if #(
  parameter int ADDR_WIDTH = 32
);
  // Command port
  logic                  cmd_valid_i;
  logic                  cmd_ready_o;
  logic                  cmd_we_i;
  logic [ADDR_WIDTH-1:0] cmd_adr_i;
  logic [31:0]           cmd_dat_i;
  logic [3:0]            cmd_sel_i;

  // Response port
  logic                  rsp_valid_o;
  logic                  rsp_ready_i;
  logic [31:0]           rsp_dat_o;
  logic [1:0]            rsp_status_o;

  // Wishbone initiator
  logic                  wb_cyc_o;
  logic                  wb_stb_o;
  logic                  wb_we_o;
  logic [ADDR_WIDTH-1:0] wb_adr_o;
  logic [3:0]            wb_sel_o;
  logic [31:0]           wb_dat_o;
  logic [31:0]           wb_dat_i;
  logic                  wb_ack_i;
  logic                  wb_err_i;
  logic                  wb_rty_i;
  logic                  wb_stall_i;

  modport master (
    input  cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i,
    output cmd_ready_o,
    input  rsp_ready_i,
    output rsp_valid_o, rsp_dat_o, rsp_status_o,
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o,
    input  wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i, wb_stall_i
  );

  modport slave (
    output cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i,
    input  cmd_ready_o,
    output rsp_ready_i,
    input  rsp_valid_o, rsp_dat_o, rsp_status_o,
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o,
    output wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i, wb_stall_i
  );
endinterface

// File: rtl/wb_single_master.sv
// -----------------------------------------------------------------------------
// wb_single_master
//
// Wishbone pipelined-mode single-transfer initiator. Each accepted command
// produces exactly one Wishbone transfer (plus re-issues on retry) and exactly
// one response carrying read data and a status code.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_n_i      asynchronous active-low reset
//   bus          wb_single_master_if.master (command, response, Wishbone)
//   dbg_state_o  current FSM state (0 IDLE, 1 REQ, 2 WAIT, 3 BACKOFF, 4 RESP)
//
// Handshakes: a transfer on the cmd or rsp port happens at a rising edge where
// valid and ready are both 1. The producer holds valid and its payload stable
// until that edge; the consumer may change ready freely. Here cmd_ready_o
// depends only on the state (1 in IDLE), and rsp_valid_o with its payload is
// held stable in RESP until rsp_ready_i is seen.
//
// Response status: 00 ok, 01 err, 10 timeout, 11 retry exhausted.
// -----------------------------------------------------------------------------
module wb_single_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 255,
  parameter int MAX_RETRY  = 3
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  wb_single_master_if.master       bus,
  output logic [2:0]               dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REQ     = 3'd1,
    S_WAIT    = 3'd2,
    S_BACKOFF = 3'd3,
    S_RESP    = 3'd4
  } state_e;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_ERR     = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;
  localparam logic [1:0] ST_RTY_EXH = 2'b11;

  // Wide enough to hold TIMEOUT and MAX_RETRY (MAX_RETRY may be 0).
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int RW = $clog2(MAX_RETRY + 2);

  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

  state_e                  state_q, state_d;
  logic                    we_q, we_d;
  logic [ADDR_WIDTH-1:0]   adr_q, adr_d;
  logic [3:0]              sel_q, sel_d;
  logic [31:0]             dat_q, dat_d;
  logic                    cyc_q, cyc_d;
  logic                    stb_q, stb_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [31:0]             rsp_dat_q, rsp_dat_d;
  logic [1:0]              rsp_status_q, rsp_status_d;
  logic [RW-1:0]           retry_q, retry_d;
  logic [TW-1:0]           tmo_q, tmo_d;

  // Terminations only count while the strobe has been (or is being) accepted:
  // in REQ that needs stall low, in WAIT they are always valid.
  logic term_en;
  logic term_ack, term_err, term_rty;

  always_comb begin
    term_en  = ((state_q == S_REQ) && !bus.wb_stall_i) || (state_q == S_WAIT);
    term_ack = term_en && bus.wb_ack_i;
    term_err = term_en && !bus.wb_ack_i && bus.wb_err_i;
    term_rty = term_en && !bus.wb_ack_i && !bus.wb_err_i && bus.wb_rty_i;
  end

  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    adr_d        = adr_q;
    sel_d        = sel_q;
    dat_d        = dat_q;
    rsp_dat_d    = rsp_dat_q;
    rsp_status_d = rsp_status_q;
    retry_d      = retry_q;
    tmo_d        = tmo_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid_i) begin
          we_d    = bus.cmd_we_i;
          adr_d   = bus.cmd_adr_i;
          sel_d   = bus.cmd_sel_i;
          dat_d   = bus.cmd_dat_i;
          retry_d = '0;
          tmo_d   = '0;
          state_d = S_REQ;
        end
      end

      S_REQ, S_WAIT: begin
        tmo_d = tmo_q + TW'(1);
        if (term_ack) begin
          rsp_status_d = ST_OK;
          rsp_dat_d    = we_q ? 32'd0 : bus.wb_dat_i;
          state_d      = S_RESP;
        end else if (term_err) begin
          rsp_status_d = ST_ERR;
          rsp_dat_d    = 32'd0;
          state_d      = S_RESP;
        end else if (term_rty) begin
          if (retry_q < RETRY_MAX) begin
            retry_d = retry_q + RW'(1);
            state_d = S_BACKOFF;
          end else begin
            rsp_status_d = ST_RTY_EXH;
            rsp_dat_d    = 32'd0;
            state_d      = S_RESP;
          end
        end else if (tmo_q == TMO_LAST) begin
          // Counter reaches TIMEOUT this cycle; a termination above wins.
          rsp_status_d = ST_TIMEOUT;
          rsp_dat_d    = 32'd0;
          state_d      = S_RESP;
        end else if ((state_q == S_REQ) && !bus.wb_stall_i) begin
          state_d = S_WAIT;
        end
      end

      S_BACKOFF: begin
        tmo_d   = '0;
        state_d = S_REQ;
      end

      S_RESP: begin
        if (bus.rsp_ready_i) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Bus and response outputs are registered versions of the next state.
    cyc_d       = (state_d == S_REQ) || (state_d == S_WAIT);
    stb_d       = (state_d == S_REQ);
    rsp_valid_d = (state_d == S_RESP);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= S_IDLE;
      we_q         <= 1'b0;
      adr_q        <= '0;
      sel_q        <= '0;
      dat_q        <= '0;
      cyc_q        <= 1'b0;
      stb_q        <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_dat_q    <= '0;
      rsp_status_q <= '0;
      retry_q      <= '0;
      tmo_q        <= '0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      adr_q        <= adr_d;
      sel_q        <= sel_d;
      dat_q        <= dat_d;
      cyc_q        <= cyc_d;
      stb_q        <= stb_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_dat_q    <= rsp_dat_d;
      rsp_status_q <= rsp_status_d;
      retry_q      <= retry_d;
      tmo_q        <= tmo_d;
    end
  end

  assign bus.cmd_ready_o  = (state_q == S_IDLE);
  assign bus.rsp_valid_o  = rsp_valid_q;
  assign bus.rsp_dat_o    = rsp_dat_q;
  assign bus.rsp_status_o = rsp_status_q;
  assign bus.wb_cyc_o     = cyc_q;
  assign bus.wb_stb_o     = stb_q;
  assign bus.wb_we_o      = we_q;
  assign bus.wb_adr_o     = adr_q;
  assign bus.wb_sel_o     = sel_q;
  assign bus.wb_dat_o     = dat_q;
  assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_wb_single_master.sv
// -----------------------------------------------------------------------------
// tb_wb_single_master
//
// Directed bench for wb_single_master (TIMEOUT=8, MAX_RETRY=3). Inputs are
// driven and outputs sampled on the falling clock edge. Expected responses
// ({status, data}) are pushed when a command is issued and popped when the
// master presents its response.
// -----------------------------------------------------------------------------
module tb_wb_single_master;

  localparam int AW = 32;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_ERR     = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;
  localparam logic [1:0] ST_RTY_EXH = 2'b11;

  localparam logic [2:0] Q_IDLE    = 3'd0;
  localparam logic [2:0] Q_WAIT    = 3'd2;
  localparam logic [2:0] Q_BACKOFF = 3'd3;
  localparam logic [2:0] Q_RESP    = 3'd4;

  logic       clk;
  logic       rst_n;
  logic [2:0] dbg_state;

  wb_single_master_if #(.ADDR_WIDTH(AW)) bus ();

  wb_single_master #(
    .ADDR_WIDTH (AW),
    .TIMEOUT    (8),
    .MAX_RETRY  (3)
  ) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // ---------------------------------------------------------------- clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ----------------------------------------------------------- scoreboard
  logic [33:0] exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // -------------------------------------------------------------- drivers
  task automatic step();
    @(negedge clk);
  endtask

  task automatic slave_drive(input logic stall, input logic ack, input logic err,
                             input logic rty, input logic [31:0] dat);
    bus.wb_stall_i = stall;
    bus.wb_ack_i   = ack;
    bus.wb_err_i   = err;
    bus.wb_rty_i   = rty;
    bus.wb_dat_i   = dat;
  endtask

  task automatic slave_quiet();
    slave_drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
  endtask

  // Called at a falling edge with the master idle. Returns in the first strobe
  // cycle, after checking the strobe and the latched bus fields.
  task automatic send_cmd(input logic we, input logic [AW-1:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, input logic [1:0] exp_st,
                          input logic [31:0] exp_dat);
    chk("cmd_ready_before_cmd", 64'(bus.cmd_ready_o), 64'(1'b1));
    bus.cmd_valid_i = 1'b1;
    bus.cmd_we_i    = we;
    bus.cmd_adr_i   = adr;
    bus.cmd_dat_i   = dat;
    bus.cmd_sel_i   = sel;
    exp_q.push_back({exp_st, exp_dat});
    step();
    bus.cmd_valid_i = 1'b0;
    bus.cmd_adr_i   = '1;
    bus.cmd_dat_i   = '1;
    bus.cmd_sel_i   = '0;
    bus.cmd_we_i    = ~we;
    chk("first_cyc", 64'(bus.wb_cyc_o), 64'(1'b1));
    chk("first_stb", 64'(bus.wb_stb_o), 64'(1'b1));
    chk("cmd_ready_busy", 64'(bus.cmd_ready_o), 64'(1'b0));
    chk("wb_we", 64'(bus.wb_we_o), 64'(we));
    chk("wb_adr", 64'(bus.wb_adr_o), 64'(adr));
    chk("wb_sel", 64'(bus.wb_sel_o), 64'(sel));
    chk("wb_dat", 64'(bus.wb_dat_o), 64'(dat));
  endtask

  // Waits (bounded) for a response, compares it with the scoreboard head and
  // consumes it.
  task automatic pop_rsp();
    logic [33:0] e;
    int k;
    k = 0;
    while (bus.rsp_valid_o !== 1'b1 && k < 20) begin
      step();
      k++;
    end
    chk("rsp_valid", 64'(bus.rsp_valid_o), 64'(1'b1));
    chk("rsp_no_cyc", 64'(bus.wb_cyc_o), 64'(1'b0));
    chk("sb_has_entry", 64'(exp_q.size() != 0), 64'(1'b1));
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("rsp_status", 64'(bus.rsp_status_o), 64'(e[33:32]));
      chk("rsp_dat", 64'(bus.rsp_dat_o), 64'(e[31:0]));
    end
    bus.rsp_ready_i = 1'b1;
    step();
    bus.rsp_ready_i = 1'b0;
    chk("rsp_consumed", 64'(bus.rsp_valid_o), 64'(1'b0));
    chk("idle_ready", 64'(bus.cmd_ready_o), 64'(1'b1));
  endtask

  // ------------------------------------------------------------- stimulus
  initial begin
    rst_n           = 1'b0;
    bus.cmd_valid_i = 1'b0;
    bus.cmd_we_i    = 1'b0;
    bus.cmd_adr_i   = '0;
    bus.cmd_dat_i   = '0;
    bus.cmd_sel_i   = '0;
    bus.rsp_ready_i = 1'b0;
    slave_quiet();

    // Reset state
    repeat (2) step();
    chk("rst_cyc", 64'(bus.wb_cyc_o), 64'(1'b0));
    chk("rst_stb", 64'(bus.wb_stb_o), 64'(1'b0));
    chk("rst_rsp_valid", 64'(bus.rsp_valid_o), 64'(1'b0));
    chk("rst_adr", 64'(bus.wb_adr_o), 64'(0));
    chk("rst_state", 64'(dbg_state), 64'(Q_IDLE));
    rst_n = 1'b1;
    step();
    chk("post_rst_ready", 64'(bus.cmd_ready_o), 64'(1'b1));

    // Terminations in IDLE are ignored
    slave_drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h9999_9999);
    step();
    slave_quiet();
    chk("idle_term_state", 64'(dbg_state), 64'(Q_IDLE));
    chk("idle_term_rsp", 64'(bus.rsp_valid_o), 64'(1'b0));

    // Zero-wait write: one strobe cycle, response at N+2, data 0
    send_cmd(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, ST_OK, 32'd0);
    slave_drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h5555_5555);
    step();
    slave_quiet();
    chk("zw_stb_one_cycle", 64'(bus.wb_stb_o), 64'(1'b0));
    chk("zw_rsp_n2", 64'(bus.rsp_valid_o), 64'(1'b1));
    pop_rsp();

    // Read with stall=~ack, ack in the second strobe cycle
    send_cmd(1'b0, 32'h20, 32'h0, 4'h3, ST_OK, 32'h1234_ABCD);
    slave_drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    step();
    chk("stall_stb_held", 64'(bus.wb_stb_o), 64'(1'b1));
    chk("stall_no_rsp", 64'(bus.rsp_valid_o), 64'(1'b0));
    slave_drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h1234_ABCD);
    step();
    slave_quiet();
    chk("stall_cyc_drop", 64'(bus.wb_cyc_o), 64'(1'b0));
    pop_rsp();

    // Read acked in WAIT (stall is ignored there)
    send_cmd(1'b0, 32'h24, 32'h0, 4'hF, ST_OK, 32'hCAFE_F00D);
    step();
    chk("wait_state", 64'(dbg_state), 64'(Q_WAIT));
    chk("wait_stb_low", 64'(bus.wb_stb_o), 64'(1'b0));
    chk("wait_cyc_high", 64'(bus.wb_cyc_o), 64'(1'b1));
    slave_drive(1'b1, 1'b1, 1'b0, 1'b0, 32'hCAFE_F00D);
    step();
    slave_quiet();
    pop_rsp();

    // Error on a read, response held for 5 cycles
    send_cmd(1'b0, 32'h30, 32'h0, 4'hF, ST_ERR, 32'd0);
    slave_drive(1'b0, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF);
    step();
    slave_quiet();
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", 64'(bus.rsp_valid_o), 64'(1'b1));
      chk("hold_dat", 64'(bus.rsp_dat_o), 64'(0));
      chk("hold_status", 64'(bus.rsp_status_o), 64'(ST_ERR));
      chk("hold_no_ready", 64'(bus.cmd_ready_o), 64'(1'b0));
      chk("hold_state", 64'(dbg_state), 64'(Q_RESP));
      step();
    end
    pop_rsp();

    // Three retries then ack: three one-cycle cyc gaps
    send_cmd(1'b1, 32'h40, 32'hA5A5_A5A5, 4'hC, ST_OK, 32'd0);
    for (int a = 0; a < 4; a++) begin
      chk("rty_stb", 64'(bus.wb_stb_o), 64'(1'b1));
      chk("rty_fields", 64'(bus.wb_dat_o), 64'(32'hA5A5_A5A5));
      if (a < 3) slave_drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
      else       slave_drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h7777_7777);
      step();
      slave_quiet();
      if (a < 3) begin
        chk("rty_gap_cyc", 64'(bus.wb_cyc_o), 64'(1'b0));
        chk("rty_gap_state", 64'(dbg_state), 64'(Q_BACKOFF));
        step();
      end
    end
    pop_rsp();

    // Four retries: exhausted after the fourth strobe
    send_cmd(1'b0, 32'h44, 32'h0, 4'hF, ST_RTY_EXH, 32'd0);
    for (int a = 0; a < 4; a++) begin
      chk("rtyx_stb", 64'(bus.wb_stb_o), 64'(1'b1));
      slave_drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h7777_7777);
      step();
      slave_quiet();
      if (a < 3) begin
        chk("rtyx_gap_cyc", 64'(bus.wb_cyc_o), 64'(1'b0));
        step();
      end
    end
    chk("rtyx_rsp_now", 64'(bus.rsp_valid_o), 64'(1'b1));
    pop_rsp();

    // Timeout: silent slave, response 8 cycles after the first strobe cycle
    send_cmd(1'b0, 32'h50, 32'h0, 4'hF, ST_TIMEOUT, 32'd0);
    for (int k = 1; k <= 8; k++) begin
      chk("tmo_cyc", 64'(bus.wb_cyc_o), 64'(1'b1));
      chk("tmo_no_rsp", 64'(bus.rsp_valid_o), 64'(1'b0));
      step();
    end
    chk("tmo_cyc_drop", 64'(bus.wb_cyc_o), 64'(1'b0));
    chk("tmo_rsp_now", 64'(bus.rsp_valid_o), 64'(1'b1));
    pop_rsp();

    // Ack on the 8th cycle beats the timeout
    send_cmd(1'b0, 32'h54, 32'h0, 4'hF, ST_OK, 32'h0BAD_F00D);
    for (int k = 1; k <= 8; k++) begin
      chk("tmo_ack_cyc", 64'(bus.wb_cyc_o), 64'(1'b1));
      if (k == 8) slave_drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0BAD_F00D);
      step();
      slave_quiet();
    end
    chk("tmo_ack_rsp_now", 64'(bus.rsp_valid_o), 64'(1'b1));
    pop_rsp();

    // Priority: ack > err > rty
    send_cmd(1'b0, 32'h60, 32'h0, 4'hF, ST_OK, 32'h1111_2222);
    slave_drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h1111_2222);
    step();
    slave_quiet();
    pop_rsp();
    send_cmd(1'b0, 32'h64, 32'h0, 4'hF, ST_ERR, 32'd0);
    slave_drive(1'b0, 1'b0, 1'b1, 1'b1, 32'h3333_3333);
    step();
    slave_quiet();
    chk("prio_err_no_backoff", 64'(dbg_state), 64'(Q_RESP));
    pop_rsp();

    // Asynchronous reset while in WAIT
    send_cmd(1'b0, 32'h70, 32'h0, 4'hF, ST_OK, 32'd0);
    step();
    chk("arst_in_wait", 64'(dbg_state), 64'(Q_WAIT));
    #2 rst_n = 1'b0;
    #1;
    chk("arst_cyc_drop", 64'(bus.wb_cyc_o), 64'(1'b0));
    chk("arst_stb_drop", 64'(bus.wb_stb_o), 64'(1'b0));
    exp_q.delete();
    step();
    step();
    chk("arst_no_rsp", 64'(bus.rsp_valid_o), 64'(1'b0));
    rst_n = 1'b1;
    step();
    chk("arst_ready", 64'(bus.cmd_ready_o), 64'(1'b1));
    send_cmd(1'b0, 32'h74, 32'h0, 4'hF, ST_OK, 32'h600D_600D);
    slave_drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h600D_600D);
    step();
    slave_quiet();
    pop_rsp();

    chk("sb_drained", 64'(exp_q.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Global guard so the run always ends.
  initial begin
    #100000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

endmodule
